// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store initiator for a word-addressed data memory.
// Byte/halfword stores are done as read-modify-write; loads are lane-extracted
// and sign/zero-extended into rdata. Misaligned or illegal accesses end in ERR.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_A,
    output logic        mem_WE,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t      state;
    state_t      req_next;
    logic        req_bad;
    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    // Only the low halfword of the store data is needed after the request:
    // word stores load the merge register straight from wdata.
    logic [15:0] wd_q;
    logic [31:0] merge_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [31:0] merge_val;

    assign mem_A  = addr_q;
    assign mem_WD = merge_q;

    // Classify the incoming request and choose the state after IDLE.
    always_comb begin
        req_bad = 1'b0;
        if (store) begin
            req_bad = (funct3 > 3'd2);
        end else begin
            req_bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end
        if (funct3[1:0] == 2'b01 && addr[0]) begin
            req_bad = 1'b1;
        end
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) begin
            req_bad = 1'b1;
        end

        if (req_bad) begin
            req_next = ERR;
        end else if (!store) begin
            req_next = LOAD;
        end else if (funct3[1:0] == 2'b10) begin
            req_next = WRITE;
        end else begin
            req_next = READ;
        end
    end

    // Lane extraction and extension for loads, lane insertion for sub-word stores.
    always_comb begin
        ld_byte = mem_RD[7:0];
        case (addr_q[1:0])
            2'd0: ld_byte = mem_RD[7:0];
            2'd1: ld_byte = mem_RD[15:8];
            2'd2: ld_byte = mem_RD[23:16];
            2'd3: ld_byte = mem_RD[31:24];
            default: ld_byte = mem_RD[7:0];
        endcase
        ld_half = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];

        case (f3_q)
            3'b000: ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001: ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100: ld_val = {24'd0, ld_byte};
            3'b101: ld_val = {16'd0, ld_half};
            default: ld_val = mem_RD;
        endcase

        merge_val = mem_RD;
        if (f3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merge_val[7:0]   = wd_q[7:0];
                2'd1: merge_val[15:8]  = wd_q[7:0];
                2'd2: merge_val[23:16] = wd_q[7:0];
                2'd3: merge_val[31:24] = wd_q[7:0];
                default: merge_val = mem_RD;
            endcase
        end else if (addr_q[1]) begin
            merge_val[31:16] = wd_q;
        end else begin
            merge_val[15:0] = wd_q;
        end
    end

    // Access sequencer with registered status and memory-control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            mem_WE  <= 1'b0;
            rdata   <= '0;
            addr_q  <= '0;
            f3_q    <= '0;
            wd_q    <= '0;
            merge_q <= '0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            mem_WE <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= addr;
                        f3_q   <= funct3;
                        wd_q   <= wdata[15:0];
                        state  <= req_next;
                        busy   <= 1'b1;
                        if (req_next == ERR) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                        if (req_next == WRITE) begin
                            merge_q <= wdata;
                            mem_WE  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    rdata <= ld_val;
                    state <= DONE;
                    done  <= 1'b1;
                end
                READ: begin
                    merge_q <= merge_val;
                    state   <= WRITE;
                    mem_WE  <= 1'b1;
                end
                WRITE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table, corner-case sequences and randomized
// accesses checked against a byte-array memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_A;
    logic        mem_WE;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    logic [31:0] dmem     [0:255];
    logic [31:0] init_img [0:255];
    logic        init_go = 1'b0;
    logic [7:0]  rbytes   [0:1023];
    logic [31:0] exp_rd;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          lat;
        logic        e;
        int          we;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl [13];

    mem_access_unit dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .store  (store),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .rdata  (rdata),
        .mem_A  (mem_A),
        .mem_WE (mem_WE),
        .mem_WD (mem_WD),
        .mem_RD (mem_RD)
    );

    always #5 clk = ~clk;

    assign mem_RD = dmem[mem_A[9:2]];

    always @(posedge clk) begin
        if (init_go) begin
            for (int i = 0; i < 256; i++) dmem[i] <= init_img[i];
        end else if (mem_WE) begin
            dmem[mem_A[9:2]] <= mem_WD;
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load_image();
        @(negedge clk);
        init_go = 1'b1;
        @(negedge clk);
        init_go = 1'b0;
    endtask

    task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output int lat, output logic e,
                             output int wecnt, output logic [31:0] lwd,
                             output logic [31:0] lwa, output logic bbad);
        @(negedge clk);
        bbad   = busy;
        req    = 1'b1;
        store  = st;
        funct3 = f3;
        addr   = a;
        wdata  = wd;
        @(negedge clk);
        req    = 1'b0;
        store  = 1'($urandom);
        funct3 = 3'($urandom);
        addr   = $urandom;
        wdata  = $urandom;
        lat    = 0;
        e      = 1'b0;
        wecnt  = 0;
        lwd    = '0;
        lwa    = '0;
        for (int k = 1; k <= 8; k++) begin
            if (!busy) bbad = 1'b1;
            if (mem_WE) begin
                wecnt++;
                lwd = mem_WD;
                lwa = mem_A;
            end
            if (done) begin
                lat = k;
                e   = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_check(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input int elat,
                             input logic ee, input int ewe, input logic [31:0] ewd,
                             input logic [31:0] erd);
        int          lat;
        int          wecnt;
        logic        e;
        logic        bbad;
        logic [31:0] lwd;
        logic [31:0] lwa;
        do_access(st, f3, a, wd, lat, e, wecnt, lwd, lwa, bbad);
        check({tag, ".done_cycle"}, 32'(lat), 32'(elat));
        check({tag, ".err"}, {31'd0, e}, {31'd0, ee});
        check({tag, ".we_pulses"}, 32'(wecnt), 32'(ewe));
        check({tag, ".busy"}, {31'd0, bbad}, 32'd0);
        check({tag, ".rdata"}, rdata, erd);
        if (ewe > 0) begin
            check({tag, ".mem_WD"}, lwd, ewd);
            check({tag, ".mem_A"}, lwa, a);
        end
    endtask

    function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int nb;
        if (st && f3 > 3'd2) return 1'b1;
        if (!st && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
        nb = 1 << f3[1:0];
        return (a % 32'(nb)) != 32'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input int nb, input logic sgn);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(rbytes[10'(a + 32'(i))]) << (8 * i));
        if (sgn && nb < 4 && v[8 * nb - 1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'd3;
        return {rbytes[10'(w + 32'd3)], rbytes[10'(w + 32'd2)],
                rbytes[10'(w + 32'd1)], rbytes[10'(w)]};
    endfunction

    initial begin
        int          lat;
        int          wecnt;
        int          nb;
        int          elat;
        int          ewe;
        logic        st;
        logic        bad;
        logic        sawbad;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ewd;
        logic [31:0] lwd;

        tbl[0]  = '{1'b0, 3'b000, 32'h101, 32'h0,        2, 1'b0, 0, 32'h0,        32'hFFFFFFAA};
        tbl[1]  = '{1'b0, 3'b100, 32'h101, 32'h0,        2, 1'b0, 0, 32'h0,        32'h000000AA};
        tbl[2]  = '{1'b0, 3'b001, 32'h102, 32'h0,        2, 1'b0, 0, 32'h0,        32'hFFFF8899};
        tbl[3]  = '{1'b0, 3'b101, 32'h102, 32'h0,        2, 1'b0, 0, 32'h0,        32'h00008899};
        tbl[4]  = '{1'b0, 3'b010, 32'h100, 32'h0,        2, 1'b0, 0, 32'h0,        32'h8899AABB};
        tbl[5]  = '{1'b1, 3'b000, 32'h103, 32'h12345677, 3, 1'b0, 1, 32'h7799AABB, 32'h8899AABB};
        tbl[6]  = '{1'b0, 3'b010, 32'h100, 32'h0,        2, 1'b0, 0, 32'h0,        32'h7799AABB};
        tbl[7]  = '{1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 2, 1'b0, 1, 32'hDEADBEEF, 32'h7799AABB};
        tbl[8]  = '{1'b0, 3'b010, 32'h104, 32'h0,        2, 1'b0, 0, 32'h0,        32'hDEADBEEF};
        tbl[9]  = '{1'b0, 3'b010, 32'h102, 32'h0,        1, 1'b1, 0, 32'h0,        32'hDEADBEEF};
        tbl[10] = '{1'b1, 3'b001, 32'h101, 32'h5555,     1, 1'b1, 0, 32'h0,        32'hDEADBEEF};
        tbl[11] = '{1'b0, 3'b011, 32'h100, 32'h0,        1, 1'b1, 0, 32'h0,        32'hDEADBEEF};
        tbl[12] = '{1'b1, 3'b100, 32'h100, 32'h1,        1, 1'b1, 0, 32'h0,        32'hDEADBEEF};

        rst    = 1'b1;
        req    = 1'b0;
        store  = 1'b0;
        funct3 = '0;
        addr   = '0;
        wdata  = '0;
        for (int i = 0; i < 256; i++) init_img[i] = '0;
        init_img[8'h40] = 32'h8899AABB;
        load_image();

        @(negedge clk);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.err", {31'd0, err}, 32'd0);
        check("reset.mem_WE", {31'd0, mem_WE}, 32'd0);
        check("reset.rdata", rdata, 32'd0);
        check("reset.mem_A", mem_A, 32'd0);
        check("reset.mem_WD", mem_WD, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_check($sformatf("vec%0d", i), tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd,
                      tbl[i].lat, tbl[i].e, tbl[i].we, tbl[i].ewd, tbl[i].erd);
        end
        check("vec.word41", dmem[8'h41], 32'hDEADBEEF);

        // Reset while an sb is in its read phase: no write, no done.
        @(negedge clk);
        req    = 1'b1;
        store  = 1'b1;
        funct3 = 3'b000;
        addr   = 32'h100;
        wdata  = 32'h55;
        @(negedge clk);
        req = 1'b0;
        check("rst_read.busy_before", {31'd0, busy}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_read.busy_now", {31'd0, busy}, 32'd0);
        check("rst_read.we_now", {31'd0, mem_WE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sawbad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_WE || done || busy) sawbad = 1'b1;
        end
        check("rst_read.quiet_after", {31'd0, sawbad}, 32'd0);
        check("rst_read.word40", dmem[8'h40], 32'h7799AABB);
        check("rst_read.rdata", rdata, 32'd0);
        run_check("rst_read.next_lw", 1'b0, 3'b010, 32'h100, 32'h0, 2, 1'b0, 0, 32'h0, 32'h7799AABB);

        // req held high for the whole of an sb: exactly one access.
        @(negedge clk);
        req    = 1'b1;
        store  = 1'b1;
        funct3 = 3'b000;
        addr   = 32'h108;
        wdata  = 32'h000000A5;
        lat    = 0;
        wecnt  = 0;
        lwd    = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_WE) begin
                wecnt++;
                lwd = mem_WD;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        req = 1'b0;
        check("held_req.done_cycle", 32'(lat), 32'd3);
        check("held_req.we_pulses", 32'(wecnt), 32'd1);
        check("held_req.mem_WD", lwd, 32'h000000A5);
        sawbad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy || done || mem_WE) sawbad = 1'b1;
        end
        check("held_req.idle_after", {31'd0, sawbad}, 32'd0);
        check("held_req.word42", dmem[8'h42], 32'h000000A5);

        // Randomized accesses against the byte-array model.
        for (int i = 0; i < 256; i++) begin
            init_img[i] = $urandom;
            for (int j = 0; j < 4; j++) rbytes[i * 4 + j] = init_img[i][8 * j +: 8];
        end
        load_image();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        exp_rd = '0;

        for (int t = 0; t < 300; t++) begin
            st = 1'($urandom);
            f3 = 3'($urandom);
            a  = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            wd  = $urandom;
            bad = model_err(st, f3, a);
            nb  = 1 << f3[1:0];
            ewe = 0;
            ewd = '0;
            if (bad) begin
                elat = 1;
            end else if (!st) begin
                elat   = 2;
                exp_rd = model_load(a, nb, !f3[2]);
            end else begin
                for (int i = 0; i < nb; i++) rbytes[10'(a + 32'(i))] = wd[8 * i +: 8];
                elat = (nb == 4) ? 2 : 3;
                ewe  = 1;
                ewd  = model_word(a);
            end
            run_check($sformatf("rand%0d", t), st, f3, a, wd, elat, bad, ewe, ewd, exp_rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator for the multi-cycle RISC-V core. It sits between the core controller and the word-addressed data memory. The memory has a combinational read and a write on the clock edge while WE is high. The unit turns RV32I byte, halfword and word accesses into word-level memory cycles, using read-modify-write for sub-word stores. It returns sign- or zero-extended load data and flags misaligned or illegal accesses.

## Interface
- No parameters; address and data widths are fixed at 32.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- store  in  1  1 = store, 0 = load; sampled with req.
- funct3  in  3  RV32I width/sign code; sampled with req.
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
- addr  in  32  byte address; sampled with req.
- wdata  in  32  store data; sampled with req.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse; also pulses on error.
- err  out  1  one-cycle pulse, coincident with done, for a misaligned or illegal access.
- rdata  out  32  extended load result; holds until the next successful load.
- mem_A  out  32  byte address to memory (memory uses A[31:2]).
- mem_WE  out  1  memory write enable.
- mem_WD  out  32  memory write data.
- mem_RD  in  32  memory read data; combinational from mem_A.

## Operation
States: IDLE, LOAD, READ, WRITE, DONE, ERR.

- **IDLE, req high:**
  - Latch store, funct3, addr and wdata into addr_q, f3_q and wd_q.
  - Classify the access and pick the next state:
    - Illegal funct3 (loads 011/110/111; stores anything other than 000/001/010) → ERR.
    - Halfword access with addr[0]=1 → ERR.
    - Word access with addr[1:0]≠00 → ERR.
    - Valid load → LOAD.
    - sw → WRITE, with merge register = wd_q.
    - sb or sh → READ.
- **IDLE, req low:** stay in IDLE.
- **LOAD:**
  - Drive mem_A = addr_q.
  - Extract the lane: byte lane addr_q[1:0], halfword lane addr_q[1], or the full word.
  - Sign-extend for lb/lh, zero-extend for lbu/lhu.
  - Register the result into rdata. Next state DONE.
- **READ:**
  - Drive mem_A = addr_q and capture mem_RD into the merge register.
  - sb: replace byte lane addr_q[1:0] with wd_q[7:0].
  - sh: replace bits [16·addr_q[1]+15 : 16·addr_q[1]] with wd_q[15:0].
  - Next state WRITE.
- **WRITE:** drive mem_A = addr_q, mem_WE = 1, mem_WD = merge register. Next state DONE.
- **DONE:** done = 1. Next state IDLE.
- **ERR:** done = 1, err = 1, no memory access, rdata unchanged. Next state IDLE.
- **Output rules:**
  - mem_WE is high only in WRITE, and for exactly one cycle per store.
  - mem_A = addr_q in all states.
  - mem_WD = merge register in all states.
  - req is ignored while busy.
  - store, funct3, addr and wdata may change after the request cycle.

## Timing
- Request sampled at edge N (IDLE, req high).
- lb/lh/lw/lbu/lhu: LOAD in cycle N+1; done and valid rdata in N+2. Total 2 cycles.
- sw: WRITE in N+1, memory updated at the end of N+1; done in N+2.
- sb/sh: READ in N+1, WRITE in N+2; done in N+3.
- Error: ERR in N+1 with done and err.
- A new req may be sampled in the cycle after done. Back-to-back throughput is one access per latency + 1 cycles.
- Reset values: state IDLE; busy, done, err, mem_WE = 0; rdata, mem_A, mem_WD, addr_q, wd_q = 0.
- Reset mid-operation: state returns to IDLE and mem_WE drops asynchronously.
  - A store in READ is abandoned with no write.
  - A store in WRITE is dropped unless the clock edge ended that cycle before rst rose.
  - No done is issued for an aborted access.
- rdata changes only on the LOAD→DONE edge.

## Test plan
Bench memory model preloaded with word 0x40 (byte address 0x100) = 0x8899AABB.
- lb at 0x101 → rdata 0xFFFFFFAA, done at N+2. lbu at 0x101 → 0x000000AA. mem_WE stays 0 throughout.
- lh at 0x102 → 0xFFFF8899. lhu at 0x102 → 0x00008899. lw at 0x100 → 0x8899AABB.
- sb at 0x103 with wdata 0x12345677 → one mem_WE pulse in N+2 with mem_WD 0x7799AABB; done at N+3; a following lw at 0x100 reads 0x7799AABB.
- sw at 0x104 with wdata 0xDEADBEEF → mem_WE only in N+1; word 0x41 = 0xDEADBEEF; done at N+2.
- Error cases, each giving done and err at N+1, no mem_WE, rdata unchanged:
  - lw at 0x102.
  - sh at 0x101.
  - load with funct3 011.
- Reset mid-access:
  - rst pulsed during READ of an sb → busy 0 immediately, no write, word 0x40 unchanged, next req accepted normally.
  - req held high during a busy access → no second access starts until IDLE.
